// File: rtl/cla_nibble_seq_if.sv
// Start/busy/done handshake and operand/result bus for cla_nibble_seq.
// The optional subtract control appears only when CLA_SEQ_SUB_EN is defined.
interface cla_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int WIDTH = 4 * NIBBLES;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] SUM;
  logic             COUT;

`ifdef CLA_SEQ_SUB_EN
  modport master (output start, A, B, CIN, sub, input busy, done, SUM, COUT);
  modport slave  (input start, A, B, CIN, sub, output busy, done, SUM, COUT);
`else
  modport master (output start, A, B, CIN, input busy, done, SUM, COUT);
  modport slave  (input start, A, B, CIN, output busy, done, SUM, COUT);
`endif
endinterface

// File: rtl/cla_nibble_seq.sv
// Wide adder built by time-sharing one 4-bit CLA slice, least significant nibble first.
// Optional subtract mode is enabled by defining CLA_SEQ_SUB_EN.
module CLA_Adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:0] carry;

  always_comb begin
    gen      = a_i & b_i;
    prop     = a_i ^ b_i;
    carry[0] = cin_i;
    carry[1] = gen[0] | (prop[0] & cin_i);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin_i);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & cin_i);
    carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & cin_i);
    sum_o    = prop ^ carry[3:0];
    cout_o   = carry[4];
  end
endmodule

module cla_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input logic             clk,
  input logic             rst,
  cla_nibble_seq_if.slave bus
);
  localparam int WIDTH = 4 * NIBBLES;
  localparam int CW    = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-5:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0]       sliceSum;
  logic             sliceCout;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] bCapture_d;
  logic             carryInit_d;

  CLA_Adder slice (
    .a_i    (aSh_q[3:0]),
    .b_i    (bSh_q[3:0]),
    .cin_i  (carry_q),
    .sum_o  (sliceSum),
    .cout_o (sliceCout)
  );

  // Subtraction reuses the adder as A + ~B + 1, so the inversion and forced carry happen at capture.
  always_comb begin
    res_d = {sliceSum, res_q};
`ifdef CLA_SEQ_SUB_EN
    bCapture_d  = bus.sub ? ~bus.B : bus.B;
    carryInit_d = bus.sub ? 1'b1 : bus.CIN;
`else
    bCapture_d  = bus.B;
    carryInit_d = bus.CIN;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            aSh_q   <= bus.A;
            bSh_q   <= bCapture_d;
            carry_q <= carryInit_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          // Carry only ever chains through carry_q, one nibble per clock.
          aSh_q   <= aSh_q >> 4;
          bSh_q   <= bSh_q >> 4;
          res_q   <= res_d[WIDTH-1:4];
          carry_q <= sliceCout;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(NIBBLES - 1)) begin
            sum_q   <= res_d;
            cout_q  <= sliceCout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;
endmodule
